// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction memory loader: FSM encoding and word packing geometry.
package instr_mem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RECV  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_ERROR = 3'd4;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned BYTES_PER_WORD    = 4;
  localparam int unsigned BYTE_IDX_W        = 2;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_ready flags the byte that completes one.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic [8*BYTES_PER_WORD-1:0]   word_next,
  output logic                          word_ready
);

  logic [BYTES_PER_WORD-1:0][7:0] bytes_q, bytes_d, merged;
  logic [BYTE_IDX_W-1:0]          idx_q, idx_d;

  // Merged view includes the byte arriving this cycle so the completed word is usable immediately.
  always_comb begin
    merged = bytes_q;
    if (byte_valid) begin
      merged[idx_q] = byte_data;
    end
  end

  assign word_next  = merged;
  assign word_ready = byte_valid && !clear && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    bytes_d = bytes_q;
    idx_d   = idx_q;
    if (clear) begin
      bytes_d = '0;
      idx_d   = '0;
    end else if (byte_valid) begin
      bytes_d = merged;
      idx_d   = idx_q + BYTE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bytes_q <= '0;
      idx_q   <= '0;
    end else begin
      bytes_q <= bytes_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from the debug UART byte stream into instruction memory via its debug write port.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_inst_mem_wr_en,
  output logic [NBITS-1:0] o_inst_mem_addr,
  output logic [NBITS-1:0] o_inst_mem_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [NBITS-1:0] o_word_count
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               wr_en_q, wr_en_d;
  logic [NBITS-1:0]   addr_q, addr_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic [NBITS-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  logic               pk_clear;
  logic               pk_valid;
  logic [31:0]        pk_word;
  logic               pk_ready;
  logic [NBITS-1:0]   word_idx_ext;
  logic               is_halt;
  logic               is_last;

  instr_mem_loader_byte_packer u_packer (
    .clk        (i_clk),
    .rst        (i_rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (i_rx_data),
    .word_next  (pk_word),
    .word_ready (pk_ready)
  );

  assign word_idx_ext = NBITS'(word_idx_q);
  assign is_halt      = (data_q == NBITS'(HALT_WORD));
  assign is_last      = (word_idx_ext + NBITS'(1)) == NBITS'(MEM_WORDS);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    pk_clear   = 1'b0;
    pk_valid   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d    = ST_RECV;
          word_idx_d = '0;
          count_d    = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          pk_clear   = 1'b1;
        end
      end
      ST_RECV: begin
        pk_valid = i_rx_valid;
        if (pk_ready) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          addr_d  = word_idx_ext << 2;
          data_d  = NBITS'(pk_word);
        end
      end
      ST_WRITE: begin
        count_d = word_idx_ext + NBITS'(1);
        if (is_halt) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (is_last) begin
          state_d    = ST_ERROR;
          busy_d     = 1'b0;
          overflow_d = 1'b1;
        end else begin
          // Packer index already wrapped to 0, so a byte here becomes byte 0 of the next word.
          state_d    = ST_RECV;
          word_idx_d = word_idx_q + IDX_W'(1);
          pk_valid   = i_rx_valid;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_inst_mem_wr_en = wr_en_q;
  assign o_inst_mem_addr  = addr_q;
  assign o_inst_mem_data  = data_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_overflow       = overflow_q;
  assign o_word_count     = count_q;

endmodule
